// File: rtl/tri_proto_pkg.sv
// Bootloader load-protocol constants, triangle type and uploader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a. Shared by the host-side uploader and the bootloader receiver.
package tri_proto_pkg;

  localparam int TRI_W     = 144;
  localparam int TRI_BYTES = TRI_W / 8;
  localparam int CNT_BYTES = 4;

  // One byte counter serves both phases, so size it for the longer one.
  localparam int IDX_W = $clog2((TRI_BYTES > CNT_BYTES) ? TRI_BYTES : CNT_BYTES);

  typedef logic [TRI_W-1:0] triangle_t;

  typedef enum logic [2:0] {
    IDLE,
    CNT_SEND,
    CNT_WAIT,
    FETCH,
    LOAD,
    TRI_SEND,
    TRI_WAIT,
    FINISH
  } upl_state_t;

endpackage

// File: rtl/triangle_uploader_tx_byte_sequencer.sv
// UART byte launcher: registers the byte and trmt strobe, detects tx_done rising edges, counts bytes.
// Latency: load_i in cycle N -> trmt_o/tx_data_o in cycle N+1; tx_done_rise_o is combinational.
// Backpressure: one byte outstanding; the caller waits for tx_done_rise_o before the next load_i.
// Ports: load_i/byte_i launch a byte; idx_clr_i/idx_inc_i steer byte_idx_o;
//        tx_done_i from the UART; trmt_o/tx_data_o to the UART.
module tx_byte_sequencer
  import tri_proto_pkg::*;
(
  input  logic             clk,
  input  logic             system_rst_n,
  input  logic             load_i,
  input  logic [7:0]       byte_i,
  input  logic             idx_clr_i,
  input  logic             idx_inc_i,
  input  logic             tx_done_i,
  output logic             trmt_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_done_rise_o,
  output logic [IDX_W-1:0] byte_idx_o
);

  logic             trmt_q;
  logic [7:0]       tx_data_q;
  logic             tx_done_q;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;

  always_comb begin
    byte_idx_d = byte_idx_q;
    if (idx_clr_i) begin
      byte_idx_d = '0;
    end else if (idx_inc_i) begin
      byte_idx_d = byte_idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      trmt_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_done_q  <= 1'b0;
      byte_idx_q <= '0;
    end else begin
      trmt_q     <= load_i;
      tx_done_q  <= tx_done_i;
      byte_idx_q <= byte_idx_d;
      if (load_i) begin
        tx_data_q <= byte_i;
      end
    end
  end

  // A level left high from the previous byte must not count as a new completion.
  assign tx_done_rise_o = tx_done_i & ~tx_done_q;
  assign trmt_o         = trmt_q;
  assign tx_data_o      = tx_data_q;
  assign byte_idx_o     = byte_idx_q;

endmodule

// File: rtl/triangle_uploader.sv
// Host-side bootloader uploader: 4-byte count then 18 bytes per triangle, all LSB first, over a UART.
// Latency: start at N -> trmt at N+1; triangle tx_done edge -> tri_rd_en +1 -> first trmt +2.
// Backpressure: waits for each tx_done rising edge; start is ignored while busy or during done.
// Ports: start/num_tris request an upload; tri_rd_* read the synchronous triangle memory;
//        tx_data/trmt/tx_done talk to the UART; busy/done/tri_index report progress.
module triangle_uploader
  import tri_proto_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              system_rst_n,
  input  logic              start,
  input  logic [31:0]       num_tris,
  output logic              tri_rd_en,
  output logic [ADDR_W-1:0] tri_rd_addr,
  input  logic [TRI_W-1:0]  tri_rd_data,
  output logic [7:0]        tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] tri_index
);

  upl_state_t        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] tri_index_q, tri_index_d;
  triangle_t         shreg_q, shreg_d;

  logic              seq_load;
  logic [7:0]        seq_byte;
  logic              idx_clr, idx_inc;
  logic              tx_rise;
  logic [IDX_W-1:0]  byte_idx;

  logic              cnt_last_byte, tri_last_byte, tri_last;
  logic [7:0]        cnt_next_byte;

  tx_byte_sequencer u_seq (
    .clk            (clk),
    .system_rst_n   (system_rst_n),
    .load_i         (seq_load),
    .byte_i         (seq_byte),
    .idx_clr_i      (idx_clr),
    .idx_inc_i      (idx_inc),
    .tx_done_i      (tx_done),
    .trmt_o         (trmt),
    .tx_data_o      (tx_data),
    .tx_done_rise_o (tx_rise),
    .byte_idx_o     (byte_idx)
  );

  assign cnt_last_byte = (byte_idx == IDX_W'(CNT_BYTES - 1));
  assign tri_last_byte = (byte_idx == IDX_W'(TRI_BYTES - 1));
  // Only consulted in TRI_WAIT, where cnt_q is known to be non-zero.
  assign tri_last      = (tri_index_q == ADDR_W'(cnt_q - 32'd1));
  // Bytes are loaded on the edge entering the SEND state, so pick the byte after the current one.
  assign cnt_next_byte = 8'(cnt_q >> {byte_idx + IDX_W'(1), 3'b000});

  always_ff @(posedge clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 32'd0;
      tri_index_q <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tri_index_q <= tri_index_d;
      shreg_q     <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = CNT_SEND;
      CNT_SEND: state_d = CNT_WAIT;
      CNT_WAIT: if (tx_rise) begin
        if (cnt_last_byte) state_d = (cnt_q != 32'd0) ? FETCH : FINISH;
        else               state_d = CNT_SEND;
      end
      FETCH:    state_d = LOAD;
      LOAD:     state_d = TRI_SEND;
      TRI_SEND: state_d = TRI_WAIT;
      TRI_WAIT: if (tx_rise) begin
        if (tri_last_byte) state_d = tri_last ? FINISH : FETCH;
        else               state_d = TRI_SEND;
      end
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // shreg holds only the bytes not yet launched; the byte for each SEND
  // state is handed to the sequencer on the edge that enters it.
  always_comb begin
    seq_load    = 1'b0;
    seq_byte    = 8'h00;
    idx_clr     = 1'b0;
    idx_inc     = 1'b0;
    cnt_d       = cnt_q;
    tri_index_d = tri_index_q;
    shreg_d     = shreg_q;
    tri_rd_en   = (state_q == FETCH);
    tri_rd_addr = tri_index_q;
    busy        = (state_q != IDLE);
    done        = (state_q == FINISH);
    tri_index   = tri_index_q;
    case (state_q)
      IDLE: if (start) begin
        cnt_d       = num_tris;
        tri_index_d = '0;
        idx_clr     = 1'b1;
        seq_load    = 1'b1;
        seq_byte    = num_tris[7:0];
      end
      CNT_WAIT: if (tx_rise) begin
        if (cnt_last_byte) begin
          idx_clr = 1'b1;
        end else begin
          idx_inc  = 1'b1;
          seq_load = 1'b1;
          seq_byte = cnt_next_byte;
        end
      end
      LOAD: begin
        shreg_d  = tri_rd_data >> 8;
        seq_load = 1'b1;
        seq_byte = tri_rd_data[7:0];
      end
      TRI_WAIT: if (tx_rise) begin
        if (tri_last_byte) begin
          idx_clr = 1'b1;
          if (!tri_last) tri_index_d = tri_index_q + 1'b1;
        end else begin
          idx_inc  = 1'b1;
          seq_load = 1'b1;
          seq_byte = shreg_q[7:0];
          shreg_d  = shreg_q >> 8;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_triangle_uploader.sv
module tb_triangle_uploader;
  import tri_proto_pkg::*;

  logic        clk = 1'b0;
  logic        system_rst_n;
  logic        start;
  logic [31:0] num_tris;
  logic        tri_rd_en;
  logic [31:0] tri_rd_addr;
  triangle_t   tri_rd_data;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic [31:0] tri_index;

  always #5 clk = ~clk;

  triangle_uploader #(.ADDR_W(32)) dut (
    .clk          (clk),
    .system_rst_n (system_rst_n),
    .start        (start),
    .num_tris     (num_tris),
    .tri_rd_en    (tri_rd_en),
    .tri_rd_addr  (tri_rd_addr),
    .tri_rd_data  (tri_rd_data),
    .tx_data      (tx_data),
    .trmt         (trmt),
    .tx_done      (tx_done),
    .busy         (busy),
    .done         (done),
    .tri_index    (tri_index)
  );

  int vectors = 0;
  int miscompares = 0;

  triangle_t  mem [0:7];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         rd_q[$];
  int         rdlat_q[$];

  int cyc = 0;
  int hold_hi = 1;
  int lat = 3;
  int age = 0;
  bit pend = 1'b0;
  int overlap = 0;
  int done_cnt = 0;
  int rd_cyc = 0;
  bit rd_wait = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // UART: captures each byte on trmt, drops tx_done hold_hi cycles later and raises it lat cycles after trmt.
  always @(posedge clk) begin
    if (!system_rst_n) begin
      pend    <= 1'b0;
      tx_done <= 1'b1;
    end else if (trmt) begin
      if (pend) overlap <= overlap + 1;
      rx_q.push_back(tx_data);
      pend <= 1'b1;
      age  <= 0;
    end else if (pend) begin
      age <= age + 1;
      if (age + 1 == hold_hi) tx_done <= 1'b0;
      if (age + 1 == lat) begin
        tx_done <= 1'b1;
        pend    <= 1'b0;
      end
    end
  end

  // Synchronous triangle memory plus read-to-first-byte latency log.
  always @(posedge clk) begin
    if (tri_rd_en) begin
      tri_rd_data <= mem[tri_rd_addr[2:0]];
      rd_q.push_back(int'(tri_rd_addr));
      rd_cyc  <= cyc;
      rd_wait <= 1'b1;
    end else if (trmt && rd_wait) begin
      rdlat_q.push_back(cyc - rd_cyc);
      rd_wait <= 1'b0;
    end
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: count LSB first, then every triangle LSB first.
  task automatic build_exp(input int n);
    logic [31:0] nv;
    nv = n;
    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(nv[8*b +: 8]);
    for (int t = 0; t < n; t++)
      for (int b = 0; b < 18; b++) exp_q.push_back(mem[t][8*b +: 8]);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 18; k++) mem[i][8*k +: 8] = 8'($urandom);
  endtask

  task automatic run_upload(input int n, input bit poke, input string tag,
                            output int n_bytes, output int n_reads);
    int rxb, rdb, lb, db, ob;
    bit got;
    logic [63:0] a;
    logic [31:0] nv;
    nv  = n;
    rxb = rx_q.size(); rdb = rd_q.size(); lb = rdlat_q.size();
    db  = done_cnt;    ob  = overlap;
    build_exp(n);
    @(negedge clk); num_tris = nv; start = 1'b1;
    @(posedge clk); #1;
    check({tag, "_trmt_start_lat"}, trmt, 1);
    check({tag, "_first_byte"}, tx_data, nv[7:0]);
    check({tag, "_busy_on"}, busy, 1);
    @(negedge clk); start = 1'b0; num_tris = $urandom;
    got = 1'b0;
    for (int c = 0; c < 20000 && !got; c++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
      else start = (poke && c == 25);
    end
    check({tag, "_done_seen"}, got, 1);
    start = got;   // arrives in the same cycle as done: must be ignored
    @(posedge clk); #1; start = 1'b0;
    check({tag, "_busy_after_done"}, busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_restart"}, busy, 0);
    n_bytes = rx_q.size() - rxb;
    n_reads = rd_q.size() - rdb;
    check({tag, "_byte_count"}, n_bytes, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      a = (rxb + i < rx_q.size()) ? 64'(rx_q[rxb + i]) : 'x;
      check($sformatf("%s_byte%0d", tag, i), a, exp_q[i]);
    end
    check({tag, "_done_pulses"}, done_cnt - db, 1);
    check({tag, "_overlap"}, overlap - ob, 0);
    check({tag, "_read_count"}, n_reads, n);
    for (int i = 0; i < n && rdb + i < rd_q.size(); i++)
      check($sformatf("%s_rd_addr%0d", tag, i), rd_q[rdb + i], i);
    for (int i = lb; i < rdlat_q.size(); i++)
      check($sformatf("%s_rd_to_trmt%0d", tag, i - lb), rdlat_q[i], 2);
    check({tag, "_tri_index"}, tri_index, (n > 0) ? n - 1 : 0);
  endtask

  typedef struct {
    int n;
    int hold;
    int l;
    bit poke;
    int exp_bytes;
    int exp_reads;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int nb, nr, base, n;
    bit seen;
    tbl[0] = '{n: 3, hold: 1, l: 3, poke: 0, exp_bytes: 58, exp_reads: 3};
    tbl[1] = '{n: 0, hold: 1, l: 4, poke: 0, exp_bytes: 4,  exp_reads: 0};
    tbl[2] = '{n: 2, hold: 4, l: 7, poke: 1, exp_bytes: 40, exp_reads: 2};
    tbl[3] = '{n: 5, hold: 1, l: 2, poke: 0, exp_bytes: 94, exp_reads: 5};
    tbl[4] = '{n: 1, hold: 3, l: 5, poke: 1, exp_bytes: 22, exp_reads: 1};

    system_rst_n = 1'b0; start = 1'b0; num_tris = 32'd0;
    randomize_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_trmt", trmt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", tri_rd_en, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rd_addr", tri_rd_addr, 0);
    check("rst_tri_index", tri_index, 0);
    @(negedge clk); system_rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single triangle with known byte pattern.
    mem[0] = 144'hDAC0_FFEE_DEAD_C0DE_ABCD_1234_5678_F00D_1337;
    base = rx_q.size();
    run_upload(1, 1'b0, "t1", nb, nr);
    check("t1_b0",  (base + 0  < rx_q.size()) ? rx_q[base + 0]  : 8'hxx, 8'h01);
    check("t1_b1",  (base + 1  < rx_q.size()) ? rx_q[base + 1]  : 8'hxx, 8'h00);
    check("t1_b4",  (base + 4  < rx_q.size()) ? rx_q[base + 4]  : 8'hxx, 8'h37);
    check("t1_b5",  (base + 5  < rx_q.size()) ? rx_q[base + 5]  : 8'hxx, 8'h13);
    check("t1_b7",  (base + 7  < rx_q.size()) ? rx_q[base + 7]  : 8'hxx, 8'hF0);
    check("t1_b20", (base + 20 < rx_q.size()) ? rx_q[base + 20] : 8'hxx, 8'hC0);
    check("t1_b21", (base + 21 < rx_q.size()) ? rx_q[base + 21] : 8'hxx, 8'hDA);

    mem[0] = 144'h0000_1111_2222_3333_4444_5555_6666_7777_8888;
    mem[1] = 144'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_ABAB_CDCD;
    mem[2] = 144'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF_0101;
    for (int i = 0; i < 5; i++) begin
      hold_hi = tbl[i].hold;
      lat     = tbl[i].l;
      run_upload(tbl[i].n, tbl[i].poke, $sformatf("tbl%0d", i), nb, nr);
      check($sformatf("tbl%0d_exp_bytes", i), nb, tbl[i].exp_bytes);
      check($sformatf("tbl%0d_exp_reads", i), nr, tbl[i].exp_reads);
    end

    // Abort during triangle byte 9, then a fresh upload from the count.
    hold_hi = 1; lat = 3;
    base = rx_q.size();
    @(negedge clk); num_tris = 32'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      if (rx_q.size() - base >= 4 + 10) seen = 1'b1;
    end
    check("rst_mid_reached", seen, 1);
    system_rst_n = 1'b0;
    #1;
    check("rst_mid_trmt", trmt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_rd_en", tri_rd_en, 0);
    check("rst_mid_tx_data", tx_data, 0);
    check("rst_mid_tri_index", tri_index, 0);
    repeat (2) @(negedge clk);
    system_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_upload(1, 1'b0, "after_rst", nb, nr);

    // Randomized uploads against the reference stream.
    for (int r = 0; r < 4; r++) begin
      randomize_mem();
      n       = $urandom_range(1, 8);
      hold_hi = 1;
      lat     = $urandom_range(2, 6);
      run_upload(n, r[0], $sformatf("rnd%0d", r), nb, nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/triangle_uploader.md
Name: triangle_uploader

Overview:
Host-side transmitter for the bootloader load protocol. It emits the byte stream the bootloader receiver expects: first a 4-byte triangle count, then each 144-bit triangle as 18 bytes, both least-significant byte first. Triangles are fetched from a local synchronous triangle memory. Bytes are handed to a UART transmitter through its trmt/tx_done handshake. Used on test/host FPGAs and in loopback benches that drive the bootloader.

Parameters:
TRI_W, 144, triangle width in bits; must be a multiple of 8
CNT_BYTES, 4, bytes in the count header
ADDR_W, 32, triangle memory address width

Ports:
clk  input  1  clock
system_rst_n  input  1  reset
start  input  1  one-cycle request to begin an upload; ignored while busy
num_tris  input  32  triangle count, sampled on the accepted start
tri_rd_en  output  1  triangle memory read strobe, one cycle
tri_rd_addr  output  ADDR_W  triangle memory read address
tri_rd_data  input  TRI_W  triangle memory read data, valid the cycle after tri_rd_en
tx_data  output  8  byte to the UART transmitter
trmt  output  1  one-cycle transmit strobe to the UART
tx_done  input  1  UART transmit-complete flag
busy  output  1  high from the accepted start until done
done  output  1  one-cycle pulse when the last byte's tx_done is seen
tri_index  output  ADDR_W  index of the triangle currently being sent

Behaviour:
- Reset: clock clk; reset system_rst_n, asynchronous, active-low. While in reset: state IDLE; trmt, tri_rd_en, busy, done = 0; tx_data, tri_rd_addr, tri_index = 0; all internal counters and shift registers = 0.
- Reset asserted mid-upload aborts immediately. No partial byte is re-sent and nothing is retained.
- tx_done handling: only its rising edge counts (tx_done & ~tx_done_q, with tx_done_q a registered copy). A level held high from an earlier byte never advances the FSM.
- trmt is a single-cycle pulse. tx_data is registered, set in the same cycle trmt rises, and held until the next load. At most one byte is outstanding.
- States and transitions:
  - IDLE: on start, latch num_tris into cnt_q, clear byte_idx and tri_index, set busy, go to CNT_SEND.
  - CNT_SEND: tx_data = cnt_q[8*byte_idx +: 8]; pulse trmt; go to CNT_WAIT.
  - CNT_WAIT: on tx_done edge:
    - if byte_idx == CNT_BYTES-1, clear byte_idx; go to FETCH if cnt_q != 0, else FINISH;
    - otherwise increment byte_idx and go to CNT_SEND.
  - FETCH: pulse tri_rd_en with tri_rd_addr = tri_index; go to LOAD.
  - LOAD: capture tri_rd_data into shreg (TRI_W bits); go to TRI_SEND.
  - TRI_SEND: tx_data = shreg[7:0]; pulse trmt; shift shreg right by 8; go to TRI_WAIT.
  - TRI_WAIT: on tx_done edge:
    - if byte_idx == TRI_W/8-1: clear byte_idx; if tri_index == cnt_q-1 go to FINISH, else increment tri_index and go to FETCH;
    - otherwise increment byte_idx and go to TRI_SEND.
  - FINISH: pulse done for one cycle, clear busy, go to IDLE.
- Latency: start accepted at cycle N gives trmt at cycle N+1. The tx_done edge ending a triangle gives tri_rd_en one cycle later; that triangle's first trmt follows 2 cycles after tri_rd_en.
- num_tris == 0: still send the 4 zero count bytes, then done. No memory reads.
- start arriving in the same cycle as done, or while busy, is ignored. A new start is accepted only in IDLE, i.e. the cycle after done.
- cnt_q arithmetic is 32-bit unsigned. cnt_q-1 is evaluated only when cnt_q != 0. tri_index never wraps: the maximum is 2^32-1.

Decomposition:
- Shared package tri_proto_pkg:
  - TRI_W, TRI_BYTES (= TRI_W/8) and CNT_BYTES;
  - typedef triangle_t (logic [TRI_W-1:0]);
  - the uploader state enum.
- The bootloader receiver imports the same constants.
- Natural sub-module: tx_byte_sequencer. It owns the trmt pulse, the tx_done edge detect and the byte_idx counter, and is shared by the count and triangle phases.

Test Plan:
- num_tris=1, mem[0]=144'hDAC0_FFEE_DEAD_C0DE_ABCD_1234_5678_F00D_1337, UART loopback to a host receiver -> bytes 01 00 00 00 37 13 0D F0 ... C0 DA (22 total), then one done pulse; busy low afterwards.
- num_tris=3, mem[0..2]=144'h0000_1111_..._8888, 144'h9999_..._CDCD, 144'hFEDC_..._0101 -> 4+54 bytes in LSB-first order; exactly 3 tri_rd_en pulses at addresses 0,1,2.
- End to end with the bootloader DUT: same 3 triangles -> bootloader triangle_valid fires 3 times, with triangle data equal to mem[0..2] and bootload_addr 0,1,2.
- num_tris=0 -> bytes 00 00 00 00, no tri_rd_en, done pulse after the 4th tx_done edge.
- tx_done held high across byte boundaries, and start pulsed while busy -> no extra trmt, no restart, byte count unchanged.
- system_rst_n asserted during triangle byte 9, then start with num_tris=1 -> immediate idle outputs (trmt=0, busy=0), then a complete fresh 22-byte stream starting from the count.
